// File: rtl/uart_tx_pkg.sv
//==============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmitter: the LOG2_CEIL
//               helper macro, the FSM state encoding constants and the state
//               enum built from them.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef LOG2_CEIL
`define LOG2_CEIL(x) ($clog2(x))
`endif

package uart_tx_pkg;

    // State encoding, kept as explicit constants so other blocks can decode it.
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = c_ST_IDLE,
        START  = c_ST_START,
        DATA   = c_ST_DATA,
        PARITY = c_ST_PARITY,
        STOP   = c_ST_STOP
    } txState_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_baud_tick_gen.sv
//==============================================================================
// Module      : baud_tick_gen
// Description : Bit-period divider. Emits a one-cycle tick every DIV clocks
//               while clear is low; clear holds the count at zero so the first
//               tick after clear releases lands exactly DIV cycles later.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-low reset
//               clear - synchronous count clear (held high while idle)
//               tick  - one-cycle pulse at the end of each bit period
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module baud_tick_gen
    import uart_tx_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int c_CNT_W = (DIV > 1) ? `LOG2_CEIL(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Decoded from the registered count; suppressed while clear is held.
    assign tick = !clear && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//==============================================================================
// Module      : uart_tx
// Description : UART transmitter. Frame = start bit, BITS data bits LSB first,
//               optional even parity bit, one stop bit. Every bit lasts
//               DIV = CLOCK_RATE/BAUD_RATE clocks.
//               Macro UART_TX_PARITY_EN : when defined, an even-parity bit is
//               sent between the data and stop bits (BITS+3 bit frame);
//               otherwise the frame is BITS+2 bits.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               tx_start - request to send tx_data (accepted only when idle)
//               tx_data  - payload, sampled on acceptance
//               TxD      - registered serial line, idle high
//               tx_busy  - high while a frame is in progress
//               tx_done  - one-cycle pulse at the end of the stop bit
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLOCK_RATE = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_start,
    input  logic [BITS-1:0] tx_data,
    output logic            TxD,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int c_DIV      = CLOCK_RATE / BAUD_RATE;
    localparam int c_BITCNT_W = `LOG2_CEIL(BITS) + 1;
    localparam logic [c_BITCNT_W-1:0] c_LAST_BIT = c_BITCNT_W'(BITS - 1);

    txState_t              r_state;
    logic [BITS-1:0]       r_shiftReg;
    logic [c_BITCNT_W-1:0] r_bitCnt;
    logic                  r_txd;
    logic                  r_busy;
    logic                  r_done;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic w_clear;
    logic w_tick;

    // The divider is held in IDLE, which also covers the acceptance cycle,
    // so the start bit gets a full DIV-cycle period.
    assign w_clear = (r_state == IDLE);

    baud_tick_gen #(
        .DIV (c_DIV)
    ) u_baudTickGen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // tx_done cycle is already IDLE, so a waiting request
                    // starts the next frame with no extra idle bit.
                    if (tx_start) begin
                        r_shiftReg <= tx_data;
                        r_bitCnt   <= '0;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_txd      <= r_shiftReg[0];
                        r_shiftReg <= r_shiftReg >> 1;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bitCnt == c_LAST_BIT) begin
                            r_bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_txd    <= r_parity;
                            r_state  <= PARITY;
`else
                            r_txd    <= 1'b1;
                            r_state  <= STOP;
`endif
                        end else begin
                            r_bitCnt   <= r_bitCnt + c_BITCNT_W'(1);
                            r_txd      <= r_shiftReg[0];
                            r_shiftReg <= r_shiftReg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign TxD     = r_txd;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//==============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with DIV = 16, BITS = 8.
//               Expected line bits are queued when a frame is requested and
//               popped at each bit centre. Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int BITS       = 8;
    localparam int BAUD_RATE  = 1;
    localparam int CLOCK_RATE = 16;
    localparam int DIV        = CLOCK_RATE / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = BITS + 3;
`else
    localparam int FRAME = BITS + 2;
`endif
    localparam int LEN = FRAME * DIV;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            tx_start = 1'b0;
    logic [BITS-1:0] tx_data  = '0;
    logic            TxD;
    logic            tx_busy;
    logic            tx_done;

    int   nCmp  = 0;
    int   nFail = 0;
    logic expQ[$];

    uart_tx #(
        .BITS       (BITS),
        .BAUD_RATE  (BAUD_RATE),
        .CLOCK_RATE (CLOCK_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .TxD      (TxD),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference frame: start, data LSB first, optional even parity, stop.
    task automatic pushFrame(input logic [BITS-1:0] d);
        expQ.push_back(1'b0);
        for (int i = 0; i < BITS; i++) expQ.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        expQ.push_back(^d);
`endif
        expQ.push_back(1'b1);
    endtask

    // Entered at the first negedge after acceptance (cycle 0 of the frame);
    // returns at the negedge of cycle LEN, where tx_done must be high.
    task automatic monitorFrame(input string tag, input int injAt, input int injLen,
                                input logic [BITS-1:0] injData);
        int   busyCnt = 0;
        int   doneCnt = 0;
        int   doneIdx = -1;
        logic expBit;
        for (int i = 0; i <= LEN; i++) begin
            if (i == injAt) begin
                tx_start = 1'b1;
                tx_data  = injData;
            end
            if (i == injAt + injLen) tx_start = 1'b0;
            if (tx_busy === 1'b1) busyCnt++;
            if (tx_done === 1'b1) begin
                doneCnt++;
                if (doneIdx < 0) doneIdx = i;
            end
            if (i % DIV == DIV / 2) begin
                expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
                check({tag, "_bit"}, 32'(TxD), 32'(expBit));
            end
            if (i < LEN) @(negedge clk);
        end
        check({tag, "_busyCycles"}, busyCnt, LEN);
        check({tag, "_doneAt"}, doneIdx, LEN);
        check({tag, "_doneCount"}, doneCnt, 1);
    endtask

    task automatic sendFrame(input string tag, input logic [BITS-1:0] d, input int injAt,
                             input int injLen, input logic [BITS-1:0] injData);
        check({tag, "_idleLine"}, 32'(TxD), 1);
        tx_data  = d;
        tx_start = 1'b1;
        pushFrame(d);
        @(negedge clk);
        tx_start = 1'b0;
        check({tag, "_startLatency"}, 32'(TxD), 0);
        monitorFrame(tag, injAt, injLen, injData);
        @(negedge clk);
        check({tag, "_doneDrop"}, 32'(tx_done), 0);
        check({tag, "_busyIdle"}, 32'(tx_busy), 0);
        check({tag, "_queue"}, expQ.size(), 0);
    endtask

    initial begin
        int lowCnt;
        int busyCnt;
        int doneCnt;

        // Reset, asserted away from any clock edge.
        #3 rst = 1'b0;
        #1;
        check("rst_TxD", 32'(TxD), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frames.
        sendFrame("a5", 8'hA5, -1, 0, 8'h00);
        sendFrame("07", 8'h07, -1, 0, 8'h00);
        repeat (3) @(negedge clk);
        sendFrame("55", 8'h55, -1, 0, 8'h00);

        // Back-to-back: tx_start held high across two frames.
        tx_data  = 8'h00;
        tx_start = 1'b1;
        pushFrame(8'h00);
        pushFrame(8'hFF);
        @(negedge clk);
        tx_data = 8'hFF;
        check("b2b_startLatency", 32'(TxD), 0);
        monitorFrame("b2b1", -1, 0, 8'h00);
        check("b2b_stopAtDone", 32'(TxD), 1);
        @(negedge clk);
        tx_start = 1'b0;
        check("b2b_noGap", 32'(TxD), 0);
        check("b2b_busyAgain", 32'(tx_busy), 1);
        monitorFrame("b2b2", -1, 0, 8'h00);
        @(negedge clk);
        check("b2b_idle", 32'(tx_busy), 0);
        check("b2b_queue", expQ.size(), 0);

        // Request of 0x3C during a 0x81 frame must be ignored.
        repeat (2) @(negedge clk);
        sendFrame("mid", 8'h81, 50, 10, 8'h3C);
        lowCnt  = 0;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lowCnt++;
            if (tx_busy !== 1'b0) busyCnt++;
        end
        check("mid_noSecondFrameTxD", lowCnt, 0);
        check("mid_noSecondFrameBusy", busyCnt, 0);

        // Reset during data bit 4 (bit 4 of 0x0F is 0, so the line is low).
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (88) @(negedge clk);
        check("rstMid_preTxD", 32'(TxD), 0);
        #2 rst = 1'b0;
        #1;
        check("rstMid_TxD", 32'(TxD), 1);
        check("rstMid_busy", 32'(tx_busy), 0);
        check("rstMid_done", 32'(tx_done), 0);
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        lowCnt  = 0;
        busyCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lowCnt++;
            if (tx_busy !== 1'b0) busyCnt++;
            if (tx_done !== 1'b0) doneCnt++;
        end
        check("rstMid_lineHigh", lowCnt, 0);
        check("rstMid_noBusy", busyCnt, 0);
        check("rstMid_noDone", doneCnt, 0);

        // A new request after reset is served normally.
        sendFrame("post", 8'h3C, -1, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BITS, default 8, data bits per frame.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter CLOCK_RATE, default 50000000, clk frequency in Hz.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_start  input  1  request to send tx_data.
REQ-007 SHALL have port tx_data  input  BITS  frame payload, sampled only on acceptance.
REQ-008 SHALL have port TxD  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at the end of the stop bit.

Function
REQ-011 SHALL derive DIV = CLOCK_RATE/BAUD_RATE (integer division); every bit lasts exactly DIV clk cycles.
REQ-012 SHALL accept tx_start only when tx_busy=0: latch tx_data into a shift register, clear the baud counter, and drive tx_busy=1 from the next cycle.
REQ-013 SHALL ignore tx_start while tx_busy=1; the current frame and latched data are unaffected.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, with transitions IDLE->START on acceptance, START->DATA after DIV cycles, DATA->(PARITY or STOP) after BITS bits, PARITY->STOP after DIV cycles, and STOP->IDLE after DIV cycles.
REQ-015 SHALL drive TxD=0 in START, data LSB-first in DATA, and TxD=1 in IDLE and STOP; TxD SHALL be registered and glitch-free.
REQ-016 SHALL start TxD low on the cycle after acceptance, giving one cycle of latency from tx_start to the start-bit edge.
REQ-017 SHALL use a bit counter of width LOG2_CEIL(BITS)+1 with no wrap-around before BITS is reached.
REQ-018 SHALL assert tx_done for exactly one cycle, concurrent with the STOP->IDLE transition; tx_busy is 0 in that same cycle.
REQ-019 SHALL accept a tx_start that arrives in the tx_done cycle, so frames run back-to-back with no extra idle bit.
REQ-020 SHALL keep the baud counter held at 0 in IDLE.

Reset
REQ-021 SHALL, while rst=0, immediately force TxD=1, tx_busy=0, tx_done=0, state=IDLE, and all counters and the shift register to 0.
REQ-022 SHALL abandon any frame in progress on reset; after rst is released, no partial frame resumes and the next frame requires a new tx_start.

Configuration
REQ-023 SHALL, when macro UART_TX_PARITY_EN is defined, send one even-parity bit (XOR of the latched data) in state PARITY between DATA and STOP, giving a frame of BITS+3 bits.
REQ-024 SHALL, when UART_TX_PARITY_EN is undefined, compile PARITY out so DATA goes directly to STOP, giving a frame of BITS+2 bits.

Structure
REQ-025 SHALL take the LOG2_CEIL macro and the FSM state encoding constants from the shared macros include.
REQ-026 SHALL place the baud divider in one sub-module, baud_tick_gen, with inputs clk, rst, and clear and output tick, where tick is a one-cycle pulse every DIV cycles.
REQ-027 SHALL keep the FSM, shift register, and bit counter in uart_tx itself.

Verification (bench: CLOCK_RATE=16, BAUD_RATE=1, so DIV=16; BITS=8)
REQ-028 SHALL cover: tx_start pulse with tx_data=0x A5, parity off -> TxD samples at bit centres are 0,1,0,1,0,0,1,0,1,1; tx_done rises 160 cycles after the start edge.
REQ-029 SHALL cover: the same stimulus with UART_TX_PARITY_EN defined, data 0x07 -> the parity bit is 1, the frame is 176 cycles long, and tx_done pulses once.
REQ-030 SHALL cover: tx_start held high for 2 frames with data 0x00 then 0xFF -> the second start bit begins the cycle after the first tx_done, with no idle gap.
REQ-031 SHALL cover: tx_start=1 with data 0x3C asserted mid-frame of 0x81 -> the 0x81 frame is transmitted unchanged and 0x3C is never sent.
REQ-032 SHALL cover: rst driven low during data bit 4 -> TxD=1 and tx_busy=0 with no clock edge; after release, TxD stays 1 for more than 200 cycles.
REQ-033 SHALL cover: a 1-cycle tx_start of 0x55 -> tx_busy stays high for exactly 160 cycles and tx_done is high for exactly 1 cycle.
